// File: rtl/bcd_to_bin.sv
// Digit-serial BCD-to-binary converter: takes NDIG BCD digits MSD first and
// accumulates acc = acc*10 + digit, presenting the result with a done pulse.
module bcd_to_bin #(
  parameter int unsigned NDIG  = 2,
  parameter int unsigned OUT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic             digit_ready,
  output logic             busy,
  output logic [OUT_W-1:0] bin_out,
  output logic             done,
  output logic             err
);

  localparam int unsigned EXT_W = OUT_W + 4;
  localparam int unsigned CNT_W = (NDIG < 2) ? 1 : $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             digit_ok;
  logic             accept;
  logic             last_digit;
  logic [EXT_W-1:0] acc_ext;
  logic [EXT_W-1:0] acc_sum;
  logic [OUT_W-1:0] acc_next;

  // acc*10 + digit at extended width; non-BCD digits contribute 0
  always_comb begin
    digit_ok   = (digit <= 4'd9);
    accept     = (state == COLLECT) && digit_valid && digit_ready;
    last_digit = (cnt == CNT_W'(NDIG - 1));
    acc_ext    = EXT_W'(acc);
    acc_sum    = (acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit_ok ? digit : 4'd0);
    acc_next   = acc_sum[OUT_W-1:0];
  end

  // bin_out is loaded on the last accepting edge so it is valid alongside done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      bin_out     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      digit_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc         <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
            digit_ready <= 1'b1;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (!digit_ok) err <= 1'b1;
            if (last_digit) begin
              bin_out     <= acc_next;
              done        <= 1'b1;
              digit_ready <= 1'b0;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy        <= 1'b0;
          digit_ready <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin (NDIG=2, OUT_W=7).
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_ready;
  logic       busy;
  logic [6:0] bin_out;
  logic       done;
  logic       err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  bcd_to_bin #(.NDIG(2), .OUT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid), .digit(digit),
    .digit_ready(digit_ready), .busy(busy), .bin_out(bin_out), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    digit_valid = 1'b1; digit = d;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({digit_ready, busy, done, err, bin_out} !== 11'd0) begin
      fails++; $display("FAIL reset_state: got %b expected 0", {digit_ready, busy, done, err, bin_out});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (digit_ready !== 1'b0) begin
      fails++; $display("FAIL ready_before_start: got %b expected 0", digit_ready);
    end
    do_start();
    tests++;
    if ({digit_ready, busy} !== 2'b11) begin
      fails++; $display("FAIL collect_flags: got %b expected 11", {digit_ready, busy});
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({digit_ready, busy, done, err, bin_out} !== 11'd0) begin
      fails++; $display("FAIL async_reset: got %b expected 0", {digit_ready, busy, done, err, bin_out});
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({digit_ready, busy} !== 2'b00) begin
      fails++; $display("FAIL ready_after_reset: got %b expected 00", {digit_ready, busy});
    end
  endtask

  task automatic test_basic();
    do_start();
    send(4'd4);
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL early_done: got %b expected 0", done);
    end
    send(4'd2);
    tests++;
    if ({done, busy, digit_ready, err, bin_out} !== {4'b1100, 7'd42}) begin
      fails++; $display("FAIL conv_42: got done=%b busy=%b rdy=%b err=%b bin=%0d expected 1 1 0 0 42",
                        done, busy, digit_ready, err, bin_out);
    end
    @(negedge clk);
    tests++;
    if ({done, busy, bin_out} !== {2'b00, 7'd42}) begin
      fails++; $display("FAIL after_done: got done=%b busy=%b bin=%0d expected 0 0 42", done, busy, bin_out);
    end
  endtask

  task automatic test_gaps();
    do_start();
    send(4'd9);
    repeat (3) @(negedge clk);
    tests++;
    if ({digit_ready, busy, done} !== 3'b110) begin
      fails++; $display("FAIL gap_hold: got %b expected 110", {digit_ready, busy, done});
    end
    send(4'd9);
    tests++;
    if ({done, bin_out} !== {1'b1, 7'd99}) begin
      fails++; $display("FAIL conv_99: got done=%b bin=%0d expected 1 99", done, bin_out);
    end
    do_start();
    send(4'd0);
    send(4'd0);
    tests++;
    if ({done, err, bin_out} !== {2'b10, 7'd0}) begin
      fails++; $display("FAIL conv_00: got done=%b err=%b bin=%0d expected 1 0 0", done, err, bin_out);
    end
  endtask

  task automatic test_invalid();
    do_start();
    send(4'd1);
    send(4'd12);
    tests++;
    if ({done, err, bin_out} !== {2'b11, 7'd10}) begin
      fails++; $display("FAIL conv_1_12: got done=%b err=%b bin=%0d expected 1 1 10", done, err, bin_out);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({err, bin_out} !== {1'b1, 7'd10}) begin
      fails++; $display("FAIL err_hold: got err=%b bin=%0d expected 1 10", err, bin_out);
    end
    do_start();
    send(4'd0);
    send(4'd7);
    tests++;
    if ({done, err, bin_out} !== {2'b10, 7'd7}) begin
      fails++; $display("FAIL conv_07: got done=%b err=%b bin=%0d expected 1 0 7", done, err, bin_out);
    end
  endtask

  task automatic test_abort_and_start();
    int base;
    do_start();
    send(4'd5);
    base = done_cnt;
    #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    do_start();
    send(4'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({digit_ready, busy, done} !== 3'b110) begin
      fails++; $display("FAIL start_in_collect: got %b expected 110", {digit_ready, busy, done});
    end
    send(4'd1);
    tests++;
    if ({done, bin_out} !== {1'b1, 7'd31}) begin
      fails++; $display("FAIL conv_31: got done=%b bin=%0d expected 1 31", done, bin_out);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if ({digit_ready, busy} !== 2'b00) begin
      fails++; $display("FAIL start_in_done: got %b expected 00", {digit_ready, busy});
    end
    tests++;
    if (done_cnt - base !== 1) begin
      fails++; $display("FAIL done_count: got %0d expected 1", done_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, d;
    int bad = 0;
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      d = a + b;
      do_start();
      send(4'(d / 10));
      send(4'(d % 10));
      if ({done, err, bin_out} !== {2'b10, 7'(d)}) begin
        bad++;
        if (bad <= 5) $display("FAIL random_%0d: got done=%b err=%b bin=%0d expected 1 0 %0d",
                               i, done, err, bin_out, d);
      end
    end
    tests++;
    if (bad != 0) fails++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_invalid();
    test_abort_and_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
